// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmit path (and the future RX stage).
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

  // Serial bit slots in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned width,
                                             input int unsigned parity_en);
    return width + 32'd2 + parity_en;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned parity_en,
                                               input int unsigned clks_per_bit);
    return frame_bits(width, parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Baud counter with synchronous clear and wrap at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST_CNT) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_bit_end = i_en && !i_clr && (r_cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serializes each byte as a UART frame.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  import fifo_uart_pkg::*;

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  uart_tx_state_t   r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic [IW-1:0]    r_bit_idx;
  logic             r_tx;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_frame_done;

  logic             w_baud_en;
  logic             w_baud_clr;
  logic             w_bit_end;

  // The baud counter only runs while a serial bit is on the line.
  always_comb begin
    w_baud_en  = 1'b0;
    w_baud_clr = 1'b0;
    case (r_state)
      ST_START, ST_DATA, ST_PARITY, ST_STOP: w_baud_en  = 1'b1;
      ST_LOAD:                               w_baud_clr = 1'b1;
      default: begin
        w_baud_en  = 1'b0;
        w_baud_clr = 1'b0;
      end
    endcase
  end

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_baud_clr),
    .i_en      (w_baud_en),
    .o_bit_end (w_bit_end)
  );

  // Frame sequencer; rdata is captured only in LOAD, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_bit_idx    <= '0;
      r_tx         <= UART_IDLE_LEVEL;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= UART_IDLE_LEVEL;
          if (tx_en && !empty) begin
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift <= rdata;
          r_par   <= even_parity(rdata);
          r_tx    <= START_LEVEL;
          r_state <= ST_START;
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == LAST_BIT) begin
              r_bit_idx <= '0;
              if (PARITY_EN) begin
                r_tx    <= r_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= UART_IDLE_LEVEL;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= UART_IDLE_LEVEL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= UART_IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_en      = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: two DUTs (parity off/on) fed by behavioural FIFOs, a line monitor decodes frames.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tx_en0 = 1'b1, tx_en1 = 1'b1;
  logic       empty0 = 1'b1, empty1 = 1'b1;
  logic [7:0] rdata0 = 8'h00, rdata1 = 8'h00;
  logic       rd_en0, tx0, busy0, fd0;
  logic       rd_en1, tx1, busy1, fd1;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en0), .empty(empty0), .rdata(rdata0),
    .rd_en(rd_en0), .tx(tx0), .busy(busy0), .frame_done(fd0));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .empty(empty1), .rdata(rdata1),
    .rd_en(rd_en1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  // Behavioural FIFOs: rdata and empty update at the edge that samples rd_en.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       rd_err0 = 1'b0, rd_err1 = 1'b0;

  always @(posedge clk) begin
    if (rd_en0) begin
      if (empty0) rd_err0 <= 1'b1;
      else        rdata0  <= q0.pop_front();
    end
    empty0 <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (rd_en1) begin
      if (empty1) rd_err1 <= 1'b1;
      else        rdata1  <= q1.pop_front();
    end
    empty1 <= (q1.size() == 0);
  end

  int   rdcnt0 = 0, rdcnt1 = 0, longp = 0;
  logic prev_rd0 = 1'b0, prev_rd1 = 1'b0;
  always @(negedge clk) begin
    if (rd_en0 && !prev_rd0) rdcnt0 <= rdcnt0 + 1;
    if (rd_en1 && !prev_rd1) rdcnt1 <= rdcnt1 + 1;
    longp    <= longp + int'(rd_en0 && prev_rd0) + int'(rd_en1 && prev_rd1);
    prev_rd0 <= rd_en0;
    prev_rd1 <= rd_en1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;
  exp_t sb[$];

  task automatic sb_push(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.par  = p;
    sb.push_back(e);
  endtask

  logic sel = 1'b0;
  logic mon_tx, mon_done;
  assign mon_tx   = sel ? tx1 : tx0;
  assign mon_done = sel ? fd1 : fd0;

  // Line monitor: decodes each frame on the selected DUT and checks it against the scoreboard.
  initial begin : monitor
    logic        prev;
    logic [10:0] bits;
    logic        glitch, aborted;
    int          nbits, flen, done_at;
    exp_t        e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (prev && !mon_tx) begin
        nbits = sel ? 11 : 10;
        flen = nbits * CPB;
        bits = '0;
        glitch = 1'b0;
        aborted = 1'b0;
        done_at = -1;
        for (int c = 0; c <= flen; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (mon_done && done_at < 0) done_at = c;
          if (c < flen) begin
            if (c % CPB == 0) bits[c / CPB] = mon_tx;
            else if (mon_tx !== bits[c / CPB]) glitch = 1'b1;
          end
        end
        if (aborted) begin
          if (sb.size() > 0) void'(sb.pop_front());
          prev = 1'b0;
        end else begin
          if (sb.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = sb.pop_front();
            check("start_bit", int'(bits[0]), 0);
            check("data_byte", int'(bits[8:1]), int'(e.data));
            if (sel) check("parity_bit", int'(bits[9]), int'(e.par));
            check("stop_bit", int'(bits[nbits-1]), 1);
            check("bit_hold_steady", int'(glitch), 0);
            check("frame_done_cycle", done_at, flen);
          end
          @(negedge clk);
          check("frame_done_width", int'(mon_done), 0);
          prev = mon_tx;
        end
      end else begin
        prev = mon_tx;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check(name, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rd0(input string name);
    int found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_en0) begin
        found = 1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    // 1: reset and idle with the FIFO empty
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", int'({tx0, rd_en0, busy0, fd0}), 8);
    end
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("idle_outputs", int'({tx0, rd_en0, busy0, fd0}), 8);
    end
    check("idle_no_fetch", rdcnt0, 0);

    // 2: single byte 0xA5, fetch-to-start latency of two cycles
    tick();
    q0.push_back(8'hA5);
    sb_push(8'hA5, 1'b0);
    wait_rd0("fetch_a5");
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (!tx0) break;
    end
    check("fetch_to_start", lat, 2);
    check("busy_in_frame", int'(busy0), 1);
    wait_drain("drain_a5", 200);
    check("rd_pulses_a5", rdcnt0, 1);
    check("busy_after_a5", int'(busy0), 0);

    // 3: back-to-back bytes
    tick(); q0.push_back(8'h01); sb_push(8'h01, 1'b0);
    tick(); q0.push_back(8'h02); sb_push(8'h02, 1'b0);
    tick(); q0.push_back(8'h03); sb_push(8'h03, 1'b0);
    wait_drain("drain_b2b", 500);
    check("rd_pulses_b2b", rdcnt0, 4);
    check("rd_err_b2b", int'(rd_err0), 0);
    check("empty_after_b2b", int'(empty0), 1);
    check("busy_after_b2b", int'(busy0), 0);

    // 4: even parity: 0x07 -> 1, 0x03 -> 0
    tick();
    sel = 1'b1;
    q1.push_back(8'h07); sb_push(8'h07, 1'b1);
    tick();
    q1.push_back(8'h03); sb_push(8'h03, 1'b0);
    wait_drain("drain_parity", 300);
    check("rd_pulses_parity", rdcnt1, 2);
    check("rd_err_parity", int'(rd_err1), 0);
    tick();
    sel = 1'b0;

    // 5: tx_en gating; dropping it mid-frame still completes that frame only
    tx_en0 = 1'b0;
    q0.push_back(8'h11); sb_push(8'h11, 1'b0);
    q0.push_back(8'h22);
    repeat (20) @(negedge clk);
    check("no_fetch_disabled", rdcnt0, 4);
    tick();
    tx_en0 = 1'b1;
    wait_rd0("fetch_enabled");
    tick();
    tick();
    tx_en0 = 1'b0;
    wait_drain("drain_txen", 200);
    repeat (60) @(negedge clk);
    check("rd_pulses_txen", rdcnt0, 5);
    check("byte_left_in_fifo", q0.size(), 1);
    check("busy_after_txen", int'(busy0), 0);

    // 6: reset during data bit 3 abandons 0x22; 0x33 follows after release
    tick();
    q0.push_back(8'h33);
    sb_push(8'h22, 1'b0);
    sb_push(8'h33, 1'b0);
    tx_en0 = 1'b1;
    wait_rd0("fetch_22");
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!tx0) begin
        lat = 1;
        break;
      end
    end
    check("start_22_seen", lat, 1);
    repeat (17) @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midframe_rst_tx", int'(tx0), 1);
    check("midframe_rst_busy", int'(busy0), 0);
    check("midframe_rst_done", int'(fd0), 0);
    check("midframe_rst_state", int'(dut0.r_state), int'(ST_IDLE));
    tick();
    rst = 1'b0;
    wait_drain("drain_after_rst", 300);
    check("rd_pulses_final", rdcnt0, 7);
    check("fifo_empty_final", q0.size(), 0);
    check("rd_err_final", int'(rd_err0 | rd_err1), 0);
    check("rd_pulse_width", longp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the synchronous byte FIFO. It pops one byte at a time using the FIFO's empty/rd_en/rdata interface and serializes each byte as an asynchronous UART frame. The frame is LSB first, with a start bit, an optional even parity bit and one stop bit, on a single tx line. It sits between the FIFO read port and the chip pad.

Parameters:
WIDTH, 8, data bits per frame; must match the FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
tx_en  input  1  permits fetching new bytes; a frame already in progress always completes.
empty  input  1  FIFO empty flag.
rdata  input  WIDTH  FIFO read data; valid one cycle after the rd_en pulse is sampled.
rd_en  output  1  FIFO pop request; registered; single-cycle pulse.
tx  output  1  serial line; idles high.
busy  output  1  high from the fetch until the stop bit completes.
frame_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - Reset values: tx=1, rd_en=0, busy=0, frame_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- State machine: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_en=1 and empty=0 at edge E0: rd_en<=1, busy<=1, go to FETCH.
  - Otherwise stay in IDLE with tx=1.
- FETCH:
  - At edge E1: rd_en<=0 (pulse is exactly 1 cycle), go to LOAD.
  - The FIFO updates rdata at this same edge.
- LOAD:
  - At edge E2: shift register<=rdata, parity<=XOR of rdata, tx<=0, baud counter<=0, go to START.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- DATA:
  - Emits bits 0..WIDTH-1, LSB first.
  - The bit index wraps to 0 after bit WIDTH-1.
  - Next state is PARITY when PARITY_EN=1, otherwise STOP.
- PARITY:
  - tx = XOR of the data bits, giving an even total count of ones.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle: frame_done<=1 for one cycle, busy<=0, go to IDLE.
- Frame timing:
  - Fetch-to-start latency is 2 cycles: rd_en rises after E0, tx falls after E2.
  - Frame length is (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles.
- Back-to-back bytes:
  - The next fetch can begin at the edge after frame_done.
  - The block never issues rd_en while the FIFO reports empty=1, so it never causes a FIFO read error.
  - The FIFO empty flag lags the read by one cycle. The minimum frame length guarantees it has settled before IDLE samples it again.
- tx_en:
  - Deasserting tx_en mid-frame does not truncate the frame.
  - Once tx_en is 0, no further fetch is issued.
- Reset mid-frame:
  - The frame is abandoned and tx=1 on the next cycle.
  - The popped byte is lost; it is not re-requested.
- rdata is sampled only in LOAD; the block ignores it at all other times.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state encoding, as localparams or a typedef enum;
  - UART_IDLE_LEVEL=1 and START_LEVEL=0;
  - a frame-length function of WIDTH and PARITY_EN.
- One natural sub-module, uart_baud_tick:
  - a CLKS_PER_BIT counter with a synchronous clear input and a single-cycle bit_end output;
  - it is reused by the future RX stage.

Test Plan:
1. Reset with CLKS_PER_BIT=4: hold rst for 3 cycles -> tx=1, rd_en=0, busy=0, frame_done=0 throughout and after release while the FIFO is empty.
2. Write 0xA5 into the FIFO -> exactly one 1-cycle rd_en pulse.
   - tx then carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
   - frame_done pulses 40 cycles after the start bit begins.
3. Write 0x01, 0x02, 0x03 back-to-back -> exactly 3 rd_en pulses and three frames in order.
   - The FIFO rd_err stays 0.
   - The FIFO empty flag is 1 after the third fetch, and busy drops after the third stop bit.
4. PARITY_EN=1, byte 0x07 -> parity bit=1 and the frame is 44 cycles long.
   - With byte 0x03 the parity bit=0.
5. tx_en=0 with 2 bytes queued -> no rd_en.
   - Raise tx_en, then drop it during the first frame: exactly 1 frame is sent and the second byte stays in the FIFO.
6. Assert rst during DATA bit 3 -> next cycle tx=1, busy=0, state IDLE.
   - After release with the FIFO non-empty, a new fetch produces the next queued byte.
